// File: rtl/icache_axi_refill.sv
// Line refill engine behind the L1 instruction cache: one 4-beat AXI4 INCR read per
// 16-byte line, with each word served to the cache as soon as its beat has landed.
module icache_axi_refill #(
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            I_req,
    input  logic [31:0]     I_addr,
    input  logic            I_write,
    input  logic [2:0]      I_type,
    output logic [31:0]     I_out,
    output logic            I_wait,
    input  logic            flush,
    output logic            err,
    output logic [ID_W-1:0] ARID,
    output logic [31:0]     ARADDR,
    output logic [3:0]      ARLEN,
    output logic [2:0]      ARSIZE,
    output logic [1:0]      ARBURST,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [ID_W-1:0] RID,
    input  logic [31:0]     RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RLAST,
    input  logic            RVALID,
    output logic            RREADY
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t      state;
    state_t      state_next;
    logic [27:0] buf_tag;
    logic [31:0] line_buf [0:3];
    logic [3:0]  word_valid;
    logic        line_pending_inval;
    logic [2:0]  beat_cnt;

    logic [1:0]  word_idx;
    logic        rd_req;
    logic        tag_match;
    logic        flush_busy;
    logic        hit;
    logic        miss;
    logic        beat;
    logic        beat_store;
    logic        unused;

    assign unused = ^{I_type, RID, I_addr[1:0]};

    assign word_idx   = I_addr[3:2];
    assign rd_req     = I_req && !I_write;
    assign tag_match  = (I_addr[31:4] == buf_tag);
    // A flush during a burst must hide valid words in the same cycle it is raised.
    assign flush_busy = flush && (state != IDLE);
    assign hit        = rd_req && tag_match && word_valid[word_idx] && !flush_busy;
    assign miss       = rd_req && !(tag_match && word_valid[word_idx]);
    assign beat       = (state == R) && RVALID;
    assign beat_store = beat && (beat_cnt != 3'd4) && (RRESP == 2'b00)
                        && !line_pending_inval && !flush;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (miss)            state_next = AR;
            AR:      if (ARREADY)         state_next = R;
            R:       if (RVALID && RLAST) state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ARVALID = (state == AR);
        RREADY  = (state == R);
        I_wait  = 1'b1;
        I_out   = '0;
        if (I_req && I_write) begin
            I_wait = 1'b0;
        end else if (hit) begin
            I_wait = 1'b0;
            I_out  = line_buf[word_idx];
        end
    end

    assign ARID    = AXI_ID;
    assign ARADDR  = {buf_tag, 4'b0000};
    assign ARLEN   = 4'd3;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    // Line tag, valid bits, beat counter and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_tag            <= '0;
            word_valid         <= '0;
            line_pending_inval <= 1'b0;
            beat_cnt           <= '0;
            err                <= 1'b0;
        end else begin
            err <= beat && (RRESP != 2'b00);
            if (state == IDLE) begin
                if (miss) begin
                    buf_tag    <= I_addr[31:4];
                    word_valid <= '0;
                    beat_cnt   <= '0;
                end else if (flush) begin
                    word_valid <= '0;
                end
            end else begin
                if (flush) begin
                    word_valid         <= '0;
                    line_pending_inval <= 1'b1;
                end
                if (beat) begin
                    if (beat_store) begin
                        word_valid[beat_cnt[1:0]] <= 1'b1;
                    end
                    if (beat_cnt != 3'd4) begin
                        beat_cnt <= beat_cnt + 3'd1;
                    end
                    if (RLAST) begin
                        line_pending_inval <= 1'b0;
                    end
                end
            end
        end
    end

    // Word storage is qualified by word_valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (beat_store) begin
            line_buf[beat_cnt[1:0]] <= RDATA;
        end
    end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Bench for icache_axi_refill: a vector table and directed burst sequences, then
// random traffic against a line-level reference model with a randomised AXI slave.
module tb_icache_axi_refill;

    localparam int unsigned     ID_W = 4;
    localparam logic [ID_W-1:0] TB_ID = 4'd5;

    logic            clk = 1'b0;
    logic            rst;
    logic            I_req;
    logic [31:0]     I_addr;
    logic            I_write;
    logic [2:0]      I_type;
    logic [31:0]     I_out;
    logic            I_wait;
    logic            flush;
    logic            err;
    logic [ID_W-1:0] ARID;
    logic [31:0]     ARADDR;
    logic [3:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [ID_W-1:0] RID;
    logic [31:0]     RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    icache_axi_refill #(.ID_W(ID_W), .AXI_ID(TB_ID)) dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_addr(I_addr), .I_write(I_write), .I_type(I_type),
        .I_out(I_out), .I_wait(I_wait), .flush(flush), .err(err),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        wr;
        logic        fl;
        logic        ardy;
        logic        rv;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        e_wait;
        logic [31:0] e_out;
        logic        e_arv;
        logic [31:0] e_araddr;
        logic        e_rrdy;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ar(input string name, input logic [31:0] addr);
        chk({name, " ARVALID"}, ARVALID, 1);
        chk({name, " ARADDR"}, ARADDR, addr);
        chk({name, " ARLEN"}, ARLEN, 3);
        chk({name, " ARSIZE"}, ARSIZE, 2);
        chk({name, " ARBURST"}, ARBURST, 1);
        chk({name, " ARID"}, ARID, TB_ID);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic drive(input logic req, input logic [31:0] addr, input logic wr, input logic fl,
                         input logic ardy, input logic rv, input logic [31:0] rd,
                         input logic [1:0] rr, input logic rl);
        @(posedge clk);
        #1;
        I_req = req; I_addr = addr; I_write = wr; flush = fl;
        ARREADY = ardy; RVALID = rv; RDATA = rd; RRESP = rr; RLAST = rl;
        I_type = 3'($urandom); RID = ID_W'($urandom);
        #4;
    endtask

    task automatic idle(input logic req, input logic [31:0] addr);
        drive(req, addr, 0, 0, 0, 0, 0, 2'b00, 0);
    endtask

    task automatic arc(input logic req, input logic [31:0] addr, input logic ardy);
        drive(req, addr, 0, 0, ardy, 0, 0, 2'b00, 0);
    endtask

    task automatic rbeat(input logic req, input logic [31:0] addr, input logic fl,
                         input logic [31:0] d, input logic [1:0] rr, input logic last);
        drive(req, addr, 0, fl, 0, 1, d, rr, last);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1; I_req = 0; I_addr = 0; I_write = 0; I_type = 0; flush = 0;
        ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
        @(posedge clk);
        #5;
        chk("reset I_wait", I_wait, 1);
        chk("reset I_out", I_out, 0);
        chk("reset ARVALID", ARVALID, 0);
        chk("reset RREADY", RREADY, 0);
        chk("reset err", err, 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // Reference model: the line buffer as a tag, four words and their valid flags,
    // plus flags describing the single outstanding line fetch.
    logic [27:0] m_tag;
    logic [31:0] m_data [4];
    logic [3:0]  m_valid;
    bit          m_fetch;
    bit          m_addr_sent;
    bit          m_inval;
    bit          m_err;
    int          m_beats;

    // Randomised AXI slave bookkeeping
    bit          s_active;
    int          s_beat;
    int          s_len;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Cold miss, zero-latency hits, write request, idle flush, early-RLAST error burst
        tbl.push_back(vec_t'{1, 32'h1004, 0, 0, 0, 0, 0,     2'b00, 0, 1, 0,     0, 0,      0, 0});
        tbl.push_back(vec_t'{1, 32'h1004, 0, 0, 1, 0, 0,     2'b00, 0, 1, 0,     1, 'h1000, 0, 0});
        tbl.push_back(vec_t'{1, 32'h1004, 0, 0, 0, 1, 'hA0, 2'b00, 0, 1, 0,     0, 0,      1, 0});
        tbl.push_back(vec_t'{1, 32'h1004, 0, 0, 0, 1, 'hA1, 2'b00, 0, 1, 0,     0, 0,      1, 0});
        tbl.push_back(vec_t'{1, 32'h1004, 0, 0, 0, 1, 'hA2, 2'b00, 0, 0, 'hA1, 0, 0,      1, 0});
        tbl.push_back(vec_t'{1, 32'h1000, 0, 0, 0, 1, 'hA3, 2'b00, 1, 0, 'hA0, 0, 0,      1, 0});
        tbl.push_back(vec_t'{1, 32'h1008, 0, 0, 0, 0, 0,     2'b00, 0, 0, 'hA2, 0, 0,      0, 0});
        tbl.push_back(vec_t'{1, 32'h100C, 0, 0, 0, 0, 0,     2'b00, 0, 0, 'hA3, 0, 0,      0, 0});
        tbl.push_back(vec_t'{1, 32'h5000, 1, 0, 0, 0, 0,     2'b00, 0, 0, 0,     0, 0,      0, 0});
        tbl.push_back(vec_t'{0, 32'h1000, 0, 0, 0, 0, 0,     2'b00, 0, 1, 0,     0, 0,      0, 0});
        tbl.push_back(vec_t'{1, 32'h1000, 0, 1, 0, 0, 0,     2'b00, 0, 0, 'hA0, 0, 0,      0, 0});
        tbl.push_back(vec_t'{1, 32'h1000, 0, 0, 0, 0, 0,     2'b00, 0, 1, 0,     0, 0,      0, 0});
        tbl.push_back(vec_t'{0, 32'h0,    0, 0, 0, 0, 0,     2'b00, 0, 1, 0,     1, 'h1000, 0, 0});
        tbl.push_back(vec_t'{0, 32'h0,    0, 0, 1, 0, 0,     2'b00, 0, 1, 0,     1, 'h1000, 0, 0});
        tbl.push_back(vec_t'{0, 32'h0,    0, 0, 0, 1, 'hB0, 2'b10, 1, 1, 0,     0, 0,      1, 0});
        tbl.push_back(vec_t'{1, 32'h1000, 0, 0, 0, 0, 0,     2'b00, 0, 1, 0,     0, 0,      0, 1});
        tbl.push_back(vec_t'{0, 32'h0,    0, 0, 0, 0, 0,     2'b00, 0, 1, 0,     1, 'h1000, 0, 0});

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.req, v.addr, v.wr, v.fl, v.ardy, v.rv, v.rdata, v.rresp, v.rlast);
            chk($sformatf("vec%0d I_wait", i), I_wait, v.e_wait);
            chk($sformatf("vec%0d I_out", i), I_out, v.e_out);
            chk($sformatf("vec%0d ARVALID", i), ARVALID, v.e_arv);
            chk($sformatf("vec%0d RREADY", i), RREADY, v.e_rrdy);
            chk($sformatf("vec%0d err", i), err, v.e_err);
            if (v.e_arv) chk_ar($sformatf("vec%0d", i), v.e_araddr);
        end

        // ARREADY stall: address phase held stable, no RREADY before the handshake
        do_reset();
        idle(1, 32'h3004);
        chk("stall miss I_wait", I_wait, 1);
        for (int i = 0; i < 5; i++) begin
            arc(0, 0, 0);
            chk_ar($sformatf("stall%0d", i), 32'h3000);
            chk($sformatf("stall%0d RREADY", i), RREADY, 0);
        end
        arc(0, 0, 1);
        chk_ar("stall hs", 32'h3000);
        for (int i = 0; i < 4; i++) begin
            rbeat(0, 0, 0, 32'h30 + 32'(i), 2'b00, i == 3);
            chk($sformatf("stall beat%0d RREADY", i), RREADY, 1);
            chk($sformatf("stall beat%0d ARVALID", i), ARVALID, 0);
        end
        idle(1, 32'h3008);
        chk("stall hit I_wait", I_wait, 0);
        chk("stall hit I_out", I_out, 32'h32);

        // Error on beat 2: pulse, word stays invalid, retry refetches the line
        do_reset();
        idle(1, 32'h1008);
        arc(0, 0, 1);
        rbeat(1, 32'h1008, 0, 32'hB0, 2'b00, 0);
        rbeat(1, 32'h1008, 0, 32'hB1, 2'b00, 0);
        rbeat(1, 32'h1008, 0, 32'hB2, 2'b10, 0);
        chk("errbeat err before", err, 0);
        rbeat(1, 32'h1008, 0, 32'hB3, 2'b00, 1);
        chk("errbeat err pulse", err, 1);
        chk("errbeat word2 I_wait", I_wait, 1);
        idle(1, 32'h1000);
        chk("errbeat err end", err, 0);
        chk("errbeat word0 I_wait", I_wait, 0);
        chk("errbeat word0 I_out", I_out, 32'hB0);
        idle(1, 32'h1008);
        chk("errbeat retry I_wait", I_wait, 1);
        arc(0, 0, 0);
        chk_ar("errbeat retry", 32'h1000);

        // Different line requested mid-burst: held off, then exactly one new fetch
        do_reset();
        idle(1, 32'h1000);
        arc(1, 32'h1000, 1);
        for (int i = 0; i < 4; i++) begin
            rbeat(1, 32'h2000, 0, 32'hC0 + 32'(i), 2'b00, i == 3);
            chk($sformatf("switch%0d I_wait", i), I_wait, 1);
            chk($sformatf("switch%0d ARVALID", i), ARVALID, 0);
        end
        idle(1, 32'h2000);
        chk("switch idle ARVALID", ARVALID, 0);
        arc(0, 0, 1);
        chk_ar("switch new", 32'h2000);
        arc(0, 0, 0);
        chk("switch single AR", ARVALID, 0);

        // Flush after the first beat: nothing of the line is ever served
        do_reset();
        idle(1, 32'h1000);
        arc(0, 0, 1);
        rbeat(0, 0, 0, 32'hD0, 2'b00, 0);
        rbeat(1, 32'h1000, 1, 32'hD1, 2'b00, 0);
        chk("flush word0 masked", I_wait, 1);
        rbeat(1, 32'h1000, 0, 32'hD2, 2'b00, 0);
        chk("flush word0 cleared", I_wait, 1);
        rbeat(1, 32'h1008, 0, 32'hD3, 2'b00, 1);
        chk("flush word2 blocked", I_wait, 1);
        idle(1, 32'h100C);
        chk("flush word3 after", I_wait, 1);
        arc(0, 0, 0);
        chk_ar("flush refetch", 32'h1000);

        // Randomised traffic against the reference model
        do_reset();
        m_tag = '0; m_valid = '0; m_fetch = 0; m_addr_sent = 0; m_inval = 0; m_err = 0; m_beats = 0;
        s_active = 0; s_beat = 0; s_len = 4;
        for (int c = 0; c < 3000; c++) begin
            logic [27:0] lines [3];
            logic [1:0]  idx;
            logic        hit_raw;
            logic        e_hit;
            logic        e_wait;
            logic [31:0] e_out;
            bit          err_next;
            int          lens [8];
            lines = '{28'h0000100, 28'h0000101, 28'h0000200};
            lens  = '{1, 2, 4, 4, 4, 4, 5, 6};

            @(posedge clk);
            #1;
            I_req   = ($urandom % 10) < 7;
            I_addr  = {lines[$urandom % 3], 2'($urandom), 2'($urandom)};
            I_write = ($urandom % 12) == 0;
            I_type  = 3'($urandom);
            flush   = ($urandom % 25) == 0;
            RID     = ID_W'($urandom);
            ARREADY = !s_active && ($urandom % 3 != 0);
            if (s_active && ($urandom % 4 != 0)) begin
                RVALID = 1;
                RDATA  = $urandom;
                RRESP  = ($urandom % 8 == 0) ? 2'b10 : 2'b00;
                RLAST  = (s_beat == s_len - 1);
            end else begin
                RVALID = 0;
                RDATA  = $urandom;
                RRESP  = 2'($urandom);
                RLAST  = 1'($urandom);
            end
            #4;

            idx     = I_addr[3:2];
            hit_raw = I_req && !I_write && (I_addr[31:4] == m_tag) && m_valid[idx];
            e_hit   = hit_raw && !(flush && m_fetch);
            e_wait  = !(e_hit || (I_req && I_write));
            e_out   = e_hit ? m_data[idx] : 32'h0;
            chk("rand I_wait", I_wait, e_wait);
            chk("rand I_out", I_out, e_out);
            chk("rand ARVALID", ARVALID, m_fetch && !m_addr_sent);
            chk("rand RREADY", RREADY, m_fetch && m_addr_sent);
            chk("rand err", err, m_err);
            if (m_fetch && !m_addr_sent) chk("rand ARADDR", ARADDR, {m_tag, 4'b0000});

            if (ARVALID && ARREADY) begin
                s_active = 1;
                s_beat   = 0;
                s_len    = lens[$urandom % 8];
            end else if (RVALID && RREADY) begin
                s_beat++;
                if (RLAST) s_active = 0;
            end

            err_next = m_fetch && m_addr_sent && RVALID && (RRESP != 2'b00);
            if (!m_fetch) begin
                if (I_req && !I_write && !hit_raw) begin
                    m_tag       = I_addr[31:4];
                    m_valid     = '0;
                    m_beats     = 0;
                    m_fetch     = 1;
                    m_addr_sent = 0;
                end else if (flush) begin
                    m_valid = '0;
                end
            end else begin
                if (flush) begin
                    m_valid = '0;
                    m_inval = 1;
                end
                if (!m_addr_sent) begin
                    if (ARREADY) m_addr_sent = 1;
                end else if (RVALID) begin
                    if (m_beats < 4 && RRESP == 2'b00 && !m_inval) begin
                        m_data[m_beats]  = RDATA;
                        m_valid[m_beats] = 1'b1;
                    end
                    if (m_beats < 4) m_beats++;
                    if (RLAST) begin
                        m_fetch = 0;
                        m_inval = 0;
                    end
                end
            end
            m_err = err_next;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
- Downstream neighbour of the L1 instruction cache.
- Takes the cache's per-word refill requests (I_req/I_addr, answered on I_out/I_wait) and services them with a single AXI4 INCR read burst per 16-byte line.
- Holds the fetched line in a 4-word buffer and returns each word as soon as its beat has arrived.
- Sits between the L1 instruction cache and the CPU wrapper's AXI master port.

Parameters:
- ID_W, 4, width of ARID/RID.
- AXI_ID, 0, value driven on ARID; RID is not checked.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- I_req  in  1  word request from cache
- I_addr  in  32  requested word byte address; [1:0] ignored
- I_write  in  1  write request (unsupported)
- I_type  in  3  access type; ignored
- I_out  out  32  returned word
- I_wait  out  1  0 = I_out valid for I_addr this cycle
- flush  in  1  invalidate line buffer
- err  out  1  one-cycle pulse on an error response
- ARID  out  ID_W  read address ID
- ARADDR  out  32  read address
- ARLEN  out  4  burst length - 1
- ARSIZE  out  3  beat size
- ARBURST  out  2  burst type
- ARVALID  out  1  read address valid
- ARREADY  in  1  read address ready
- RID  in  ID_W  read ID (not checked)
- RDATA  in  32  read data
- RRESP  in  2  read response
- RLAST  in  1  last beat
- RVALID  in  1  read data valid
- RREADY  out  1  read data ready

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk.
- Reset values:
  - state=IDLE, ARVALID=0, RREADY=0, err=0, I_out=0, I_wait=1.
  - buf_tag=0, word_valid=4'b0000, line_pending_inval=0, beat_cnt=0.
- Storage:
  - buf_tag[27:0] holds the line address.
  - buf[0..3] hold 32-bit words.
  - word_valid[3:0] holds one valid bit per word.
- Hit (combinational, any state):
  - Condition: I_req && !I_write && I_addr[31:4]==buf_tag && word_valid[I_addr[3:2]].
  - Response: I_wait=0, I_out=buf[I_addr[3:2]].
  - Otherwise I_wait=1 and I_out=0.
- Write request: I_req && I_write gives I_wait=0 and I_out=0 in the same cycle. No AXI traffic and no state change.
- States: IDLE, AR, R.
- IDLE:
  - A read request that is not a hit (tag mismatch or word invalid) latches buf_tag=I_addr[31:4], clears word_valid, sets beat_cnt=0, and goes to AR.
  - ARVALID is first asserted the cycle after the miss.
- AR:
  - ARVALID=1, ARADDR={buf_tag,4'b0000}, ARLEN=4'd3, ARSIZE=3'b010, ARBURST=2'b01, ARID=AXI_ID.
  - ARADDR/ARVALID stay stable until ARREADY=1.
  - On the ARREADY handshake, go to R.
- R:
  - RREADY=1.
  - Each RVALID beat with beat_cnt<4 and RRESP==2'b00 writes buf[beat_cnt]=RDATA and sets word_valid[beat_cnt].
  - beat_cnt increments on every beat, saturating at 4.
  - A word is hit-visible the cycle after its beat is accepted.
  - An RVALID&&RLAST beat returns to IDLE.
- Error beat (RRESP!=0): data is not stored, word_valid stays 0, and err pulses for 1 cycle. The burst continues to RLAST. A retried request then refetches the line.
- Extra beats beyond 4 before RLAST are accepted and dropped.
- An early RLAST (<4 beats) ends the burst; the missing words remain invalid.
- Request for a different line during AR/R: I_wait=1 and the burst is not aborted. In IDLE afterwards the request misses and starts a new fetch.
- flush:
  - In IDLE: word_valid is cleared next cycle.
  - In AR/R: word_valid is cleared immediately, and line_pending_inval=1 blocks setting any valid bit for the rest of the burst. It is cleared on return to IDLE.
  - flush and a miss in the same IDLE cycle: the miss takes priority, and the new fetch starts with cleared valids.
- Reset mid-burst returns everything to reset values. The AXI slave shares rst.
- Only one AXI transaction is outstanding at any time.

Test Plan:
- Cold miss: I_req=1, I_addr=0x0000_1004. Expected: ARVALID the next cycle with ARADDR=0x1000, ARLEN=3, ARSIZE=2, ARBURST=1. Slave returns 0xA0,0xA1,0xA2,0xA3 (RLAST on the 4th). I_wait drops the cycle after beat 1 with I_out=0xA1; then addr 0x1000/0x1008/0x100C return 0xA0/0xA2/0xA3 with zero latency.
- ARREADY held low 5 cycles: ARVALID/ARADDR remain stable for all 5 cycles. No RREADY until the handshake.
- Error beat: beat 2 returns RRESP=2'b10. Expected: err pulses 1 cycle, and a request to word 2 keeps I_wait=1. After RLAST, a retry issues a new AR to the same line.
- Line switch mid-burst: a request to 0x2000 during the R phase of line 0x1000 holds I_wait=1. Exactly one AR to 0x2000 follows the RLAST of the first burst.
- Flush mid-burst: flush asserted after beat 1. Expected: no word of line 0x1000 is ever hit-visible, and the next request refetches.
- I_write=1 request: I_wait=0 and I_out=0 the same cycle, with ARVALID never asserted.
